tour_cmd_sequencer: RTL and testbench

//  Scripted command player for Knight tour runs. Holds a programmable list of
//  16-bit move/cal commands and issues them one at a time to RemoteComm
//  (cmd/snd_cmd). Each command waits for cmd_snt, then for resp; the resp is

---
 rtl/tour_cmd_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_tour_cmd_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd_sequencer.sv
// Scripted command player: replays up to DEPTH stored commands to RemoteComm, one per cmd_snt/resp round.
// Define SEQ_RETRY_EN to re-issue a nacked or timed-out command up to MAX_RETRY times before failing.
module tour_cmd_sequencer #(
  parameter int                DEPTH          = 16,
  parameter int                CMD_W          = 16,
  parameter int                RESP_W         = 8,
  parameter logic [RESP_W-1:0] ACK_VAL        = 8'hA5,
  parameter logic [23:0]       TIMEOUT_CYCLES = 24'd2000000,
  parameter int                MAX_RETRY      = 2,
  localparam int               AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int               CW             = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_we,
  input  logic [AW-1:0]     load_addr,
  input  logic [CMD_W-1:0]  load_data,
  input  logic [CW-1:0]     num_cmds,
  input  logic              start,
  input  logic              abort,
  output logic [CMD_W-1:0]  cmd,
  output logic              snd_cmd,
  input  logic              cmd_snt,
  input  logic              resp_rdy,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CW-1:0]     cur_idx
);

  localparam int RW = $clog2(MAX_RETRY + 2);
`ifdef SEQ_RETRY_EN
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
`else
  localparam logic [RW-1:0] RETRY_LIM = '0;
`endif

  localparam logic [1:0] CODE_NACK    = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;
  localparam logic [1:0] CODE_ABORT   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_SNT, S_WAIT_RESP, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [CMD_W-1:0]  script [DEPTH];
  logic [CW-1:0]     n_cmds, n_nxt, cur_idx_nxt;
  logic [CMD_W-1:0]  cmd_nxt;
  logic [23:0]       timer, timer_nxt;
  logic [RW-1:0]     retry, retry_nxt;
  logic              busy_nxt, done_nxt, err_nxt, snd_nxt;
  logic [1:0]        err_code_nxt, fail_code;
  logic              load_ok, timed_out, fail, playing;
  logic [AW-1:0]     rd_idx;

  assign load_ok   = load_we && !busy;
  assign timed_out = (timer == TIMEOUT_CYCLES - 24'd1);
  assign playing   = state inside {S_ISSUE, S_WAIT_SNT, S_WAIT_RESP, S_NEXT};

  always_ff @(posedge clk) begin
    if (load_ok) script[load_addr] <= load_data;
  end

  always_comb begin
    state_nxt    = state;
    n_nxt        = n_cmds;
    cur_idx_nxt  = cur_idx;
    timer_nxt    = timer;
    retry_nxt    = retry;
    busy_nxt     = busy;
    done_nxt     = done;
    err_nxt      = err;
    err_code_nxt = err_code;
    cmd_nxt      = cmd;
    snd_nxt      = 1'b0;
    fail         = 1'b0;
    fail_code    = 2'b00;
    rd_idx       = '0;

    case (state)
      S_IDLE: begin
        if (start) begin
          n_nxt        = (num_cmds > CW'(DEPTH)) ? CW'(DEPTH) : num_cmds;
          cur_idx_nxt  = '0;
          retry_nxt    = '0;
          busy_nxt     = 1'b1;
          done_nxt     = 1'b0;
          err_nxt      = 1'b0;
          err_code_nxt = 2'b00;
          state_nxt    = (n_nxt == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_nxt = '0;
        state_nxt = S_WAIT_SNT;
      end
      S_WAIT_SNT: begin
        timer_nxt = timer + 24'd1;
        if (timed_out) begin
          fail      = 1'b1;
          fail_code = CODE_TIMEOUT;
        end else if (cmd_snt) begin
          state_nxt = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        timer_nxt = timer + 24'd1;
        // A response arriving on the last timer clock still counts.
        if (resp_rdy) begin
          if (resp == ACK_VAL) begin
            cur_idx_nxt = cur_idx + CW'(1);
            retry_nxt   = '0;
            state_nxt   = S_NEXT;
          end else begin
            fail      = 1'b1;
            fail_code = CODE_NACK;
          end
        end else if (timed_out) begin
          fail      = 1'b1;
          fail_code = CODE_TIMEOUT;
        end
      end
      S_NEXT: begin
        state_nxt = (cur_idx == n_cmds) ? S_DONE : S_ISSUE;
      end
      S_DONE, S_ERROR: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (fail) begin
      if (retry != RETRY_LIM) begin
        retry_nxt = retry + RW'(1);
        state_nxt = S_ISSUE;
      end else begin
        state_nxt    = S_ERROR;
        err_code_nxt = fail_code;
      end
    end

    // Abort overrides any ack, nack or timeout decided this clock.
    if (abort && playing) begin
      state_nxt    = S_ERROR;
      err_code_nxt = CODE_ABORT;
      cur_idx_nxt  = cur_idx;
      retry_nxt    = retry;
    end

    if (state_nxt == S_DONE)  done_nxt = 1'b1;
    if (state_nxt == S_ERROR) err_nxt  = 1'b1;

    // A same-clock script write to the entry about to be issued is forwarded.
    if (state_nxt == S_ISSUE) begin
      rd_idx  = cur_idx_nxt[AW-1:0];
      snd_nxt = 1'b1;
      cmd_nxt = (load_ok && load_addr == rd_idx) ? load_data : script[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      n_cmds   <= '0;
      cur_idx  <= '0;
      timer    <= '0;
      retry    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
      cmd      <= '0;
      snd_cmd  <= 1'b0;
    end else begin
      state    <= state_nxt;
      n_cmds   <= n_nxt;
      cur_idx  <= cur_idx_nxt;
      timer    <= timer_nxt;
      retry    <= retry_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      err_code <= err_code_nxt;
      cmd      <= cmd_nxt;
      snd_cmd  <= snd_nxt;
    end
  end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Directed bench for tour_cmd_sequencer: table of playback runs plus hand-written timeout/abort/load corner sequences.
module tb_tour_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_we;
  logic [3:0]  load_addr;
  logic [15:0] load_data;
  logic [4:0]  num_cmds;
  logic        start;
  logic        abort;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [4:0]  cur_idx;

  tour_cmd_sequencer #(
    .DEPTH(16), .CMD_W(16), .RESP_W(8), .ACK_VAL(8'hA5),
    .TIMEOUT_CYCLES(24'd1000), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .num_cmds(num_cmds), .start(start), .abort(abort),
    .cmd(cmd), .snd_cmd(snd_cmd), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy),
    .resp(resp), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      n;
    int              nresp;     // responses beyond this list are acks
    logic [2:0][7:0] r;
    logic            exp_done;
    logic            exp_err;
    logic [1:0]      exp_code;
    int              exp_idx;
    int              exp_snd;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] smodel [16];
  vec_t        vt [6];

  function automatic vec_t mk(input logic [4:0] n, input int nr, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] c, input logic ed,
                              input logic ee, input logic [1:0] ec, input int ei, input int es);
    vec_t v;
    v.n = n; v.nresp = nr; v.r[0] = a; v.r[1] = b; v.r[2] = c;
    v.exp_done = ed; v.exp_err = ee; v.exp_code = ec; v.exp_idx = ei; v.exp_snd = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic handshake(input logic [7:0] r);
    @(negedge clk); cmd_snt = 1'b1;
    @(negedge clk); cmd_snt = 1'b0;
    @(negedge clk); resp = r; resp_rdy = 1'b1;
    @(negedge clk); resp_rdy = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy && c < 200) begin
      @(negedge clk);
      c++;
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic start_run(input logic [4:0] n);
    num_cmds = n; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic play(input int k, input vec_t v);
    int snd, ri, acks, cyc;
    logic [7:0] r;
    snd = 0; ri = 0; acks = 0; cyc = 0;
    start_run(v.n);
    while (busy && cyc < 3000) begin
      if (snd_cmd) begin
        snd++;
        check($sformatf("v%0d_cmd%0d", k, snd), {16'd0, cmd}, {16'd0, smodel[acks]});
        r = 8'hA5;
        if (ri < v.nresp) r = v.r[ri];
        handshake(r);
        if (r == 8'hA5) acks++;
        ri++;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    check($sformatf("v%0d_busy", k), {31'd0, busy}, 32'd0);
    check($sformatf("v%0d_snd", k), snd, v.exp_snd);
    check($sformatf("v%0d_done", k), {31'd0, done}, {31'd0, v.exp_done});
    check($sformatf("v%0d_err", k), {31'd0, err}, {31'd0, v.exp_err});
    check($sformatf("v%0d_code", k), {30'd0, err_code}, {30'd0, v.exp_code});
    check($sformatf("v%0d_idx", k), {27'd0, cur_idx}, v.exp_idx);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0; num_cmds = '0;
    start = 1'b0; abort = 1'b0; cmd_snt = 1'b0; resp_rdy = 1'b0; resp = '0;

    vt[0] = mk(5'd2, 2, 8'hA5, 8'hA5, 8'h00, 1'b1, 1'b0, 2'b00, 2, 2);
    vt[2] = mk(5'd20, 0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 16, 16);
    vt[5] = mk(5'd3, 0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 3, 3);
`ifdef SEQ_RETRY_EN
    vt[1] = mk(5'd2, 2, 8'hA5, 8'h5A, 8'h00, 1'b1, 1'b0, 2'b00, 2, 3);
    vt[3] = mk(5'd1, 3, 8'h5A, 8'h5A, 8'hA5, 1'b1, 1'b0, 2'b00, 1, 3);
    vt[4] = mk(5'd1, 3, 8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b1, 2'b01, 0, 3);
`else
    vt[1] = mk(5'd2, 2, 8'hA5, 8'h5A, 8'h00, 1'b0, 1'b1, 2'b01, 1, 2);
    vt[3] = mk(5'd1, 3, 8'h5A, 8'h5A, 8'hA5, 1'b0, 1'b1, 2'b01, 0, 1);
    vt[4] = mk(5'd1, 3, 8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b1, 2'b01, 0, 1);
`endif

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_code", {30'd0, err_code}, 32'd0);
    check("rst_idx", {27'd0, cur_idx}, 32'd0);
    check("rst_snd", {31'd0, snd_cmd}, 32'd0);
    check("rst_cmd", {16'd0, cmd}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      smodel[i] = (i == 0) ? 16'h4BF1 : (i == 1) ? 16'h57F2 : 16'h1000 + 16'(i) * 16'h0111;
      load_we = 1'b1; load_addr = 4'(i); load_data = smodel[i];
      @(negedge clk);
    end
    load_we = 1'b0;

    for (int i = 0; i < 6; i++) begin
      play(i, vt[i]);
      @(negedge clk);
    end

    // Zero-length script finishes at once; a start during the DONE clock is ignored.
    start_run(5'd0);
    check("n0_done", {31'd0, done}, 32'd1);
    check("n0_snd", {31'd0, snd_cmd}, 32'd0);
    check("n0_busy_in_done", {31'd0, busy}, 32'd1);
    num_cmds = 5'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("n0_start_ignored_busy", {31'd0, busy}, 32'd0);
    check("n0_start_ignored_snd", {31'd0, snd_cmd}, 32'd0);
    check("n0_done_sticky", {31'd0, done}, 32'd1);

    // Abort while idle changes nothing.
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    @(negedge clk);
    check("idle_abort_err", {31'd0, err}, 32'd0);
    check("idle_abort_busy", {31'd0, busy}, 32'd0);

    // Wait clock 0 is the first clock after the snd_cmd pulse; timer hits 999 on wait clock 999.
    start_run(5'd1);
    check("to_snd", {31'd0, snd_cmd}, 32'd1);
    @(negedge clk); cmd_snt = 1'b1;
    @(negedge clk); cmd_snt = 1'b0; w = 1;
    while (!err && !snd_cmd && w < 1100) begin
      @(negedge clk);
      w++;
    end
    check("to_clk", w, 1000);
`ifdef SEQ_RETRY_EN
    check("to_reissue", {31'd0, snd_cmd}, 32'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("to_abort_code", {30'd0, err_code}, 32'd3);
`else
    check("to_err", {31'd0, err}, 32'd1);
    check("to_code", {30'd0, err_code}, 32'd2);
`endif
    wait_idle("to");

    start_run(5'd1);
    @(negedge clk); cmd_snt = 1'b1;
    @(negedge clk); cmd_snt = 1'b0; w = 1;
    while (w < 999) begin
      @(negedge clk);
      w++;
    end
    resp = 8'hA5; resp_rdy = 1'b1;
    @(negedge clk); resp_rdy = 1'b0;
    check("late_ack_err", {31'd0, err}, 32'd0);
    wait_idle("late_ack");
    check("late_ack_done", {31'd0, done}, 32'd1);
    check("late_ack_code", {30'd0, err_code}, 32'd0);

    // Abort in WAIT_RESP of command 0; a later response must be ignored.
    start_run(5'd2);
    @(negedge clk); cmd_snt = 1'b1;
    @(negedge clk); cmd_snt = 1'b0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("ab_err", {31'd0, err}, 32'd1);
    check("ab_code", {30'd0, err_code}, 32'd3);
    check("ab_idx", {27'd0, cur_idx}, 32'd0);
    @(negedge clk);
    check("ab_busy", {31'd0, busy}, 32'd0);
    resp = 8'hA5; resp_rdy = 1'b1;
    @(negedge clk); resp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("ab_late_done", {31'd0, done}, 32'd0);
    check("ab_late_code", {30'd0, err_code}, 32'd3);
    check("ab_late_snd", {31'd0, snd_cmd}, 32'd0);

    // Write + start on one clock plays the new entry; a write while busy is dropped.
    load_we = 1'b1; load_addr = 4'd0; load_data = 16'hBEEF; num_cmds = 5'd2; start = 1'b1;
    @(negedge clk); load_we = 1'b0; start = 1'b0;
    smodel[0] = 16'hBEEF;
    check("ld_snd0", {31'd0, snd_cmd}, 32'd1);
    check("ld_cmd0", {16'd0, cmd}, {16'd0, smodel[0]});
    @(negedge clk); cmd_snt = 1'b1; load_we = 1'b1; load_addr = 4'd1; load_data = 16'hDEAD;
    @(negedge clk); cmd_snt = 1'b0; load_we = 1'b0;
    @(negedge clk); resp = 8'hA5; resp_rdy = 1'b1;
    check("ld_cmd0_held", {16'd0, cmd}, {16'd0, smodel[0]});
    @(negedge clk); resp_rdy = 1'b0;
    check("ld_gap_snd", {31'd0, snd_cmd}, 32'd0);
    @(negedge clk);
    check("ld_snd1", {31'd0, snd_cmd}, 32'd1);
    check("ld_cmd1", {16'd0, cmd}, {16'd0, smodel[1]});
    handshake(8'hA5);
    wait_idle("ld");
    check("ld_done", {31'd0, done}, 32'd1);
    check("ld_idx", {27'd0, cur_idx}, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
